// File: rtl/neos2test_pio_pkg.sv
// Shared register offsets and edge-select codes for the input PIO.
package neos2test_pio_pkg;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RSVD    = 2'd1;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/neos2test_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; output is 2 cycles behind d.
module neos2test_sync2 #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/neos2test_pio_in.sv
// Avalon-MM input PIO: synchronized data, edge capture (write-1-to-clear) and masked level irq.
// Zero wait states, zero read latency; irq registered from the captured/masked state.
module neos2test_pio_in
  import neos2test_pio_pkg::*;
#(
  parameter int               WIDTH      = 10,
  parameter int               EDGE_TYPE  = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  neos2test_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= sync2;
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_vec = ~sync2 & prev;
      EDGE_ANY:  edge_vec = sync2 ^ prev;
      default:   edge_vec = sync2 & ~prev;
    endcase
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    clr = '0;
    if (wr_en && address == PIO_EDGECAP) clr = writedata[WIDTH-1:0];
  end

  // Edge OR-ed in after the clear so a same-cycle set beats a write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= (edgecap & ~clr) | edge_vec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= RESET_MASK;
    end else if (wr_en && address == PIO_IRQMASK) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edgecap & irqmask);
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_DATA:    readdata[WIDTH-1:0] = sync2;
      PIO_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      PIO_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:     readdata = '0;
    endcase
  end

  if (WIDTH < 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_neos2test_pio_in.sv
// Directed bench for the input PIO: one instance per edge mode sharing a bus, scoreboarded reads.
module tb_neos2test_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  vecs = 0;
  int  miss = 0;

  always #10 clk = ~clk;

  neos2test_pio_in #(.WIDTH(10), .EDGE_TYPE(0), .RESET_MASK(10'h000)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

  neos2test_pio_in #(.WIDTH(10), .EDGE_TYPE(1), .RESET_MASK(10'h155)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));

  neos2test_pio_in #(.WIDTH(10), .EDGE_TYPE(2), .RESET_MASK(10'h2AA)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

  function automatic logic [31:0] rd_of(input int dev);
    case (dev)
      1:       return rd1;
      2:       return rd2;
      default: return rd0;
    endcase
  endfunction

  function automatic logic irq_of(input int dev);
    case (dev)
      1:       return irq1;
      2:       return irq2;
      default: return irq0;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    sb_t e;
    vecs++;
    if (sb.size() == 0) begin
      miss++;
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miss++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk_rd(input int dev, input logic [1:0] a, input string tag, input logic [31:0] v);
    push(tag, v);
    address = a;
    #1;
    compare(rd_of(dev));
  endtask

  task automatic chk_irq(input int dev, input string tag, input logic v);
    push(tag, {31'b0, v});
    compare({31'b0, irq_of(dev)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 10'h3FF;
    #45;

    // Reset state, in_port held high.
    chk_irq(0, "rst_irq0", 1'b0);
    chk_irq(1, "rst_irq1", 1'b0);
    chk_irq(2, "rst_irq2", 1'b0);
    chk_rd(0, 2'd0, "rst_data0", 32'h0);
    chk_rd(0, 2'd1, "rst_rsvd0", 32'h0);
    chk_rd(0, 2'd2, "rst_mask0", 32'h0);
    chk_rd(0, 2'd3, "rst_ecap0", 32'h0);
    chk_rd(1, 2'd2, "rst_mask1", 32'h155);
    chk_rd(1, 2'd3, "rst_ecap1", 32'h0);
    chk_rd(2, 2'd0, "rst_data2", 32'h0);
    chk_rd(2, 2'd2, "rst_mask2", 32'h2AA);

    @(negedge clk);
    reset_n = 1'b1;
    tick(5);

    // High input through reset release looks like a rising edge.
    chk_rd(0, 2'd0, "post_rst_data0", 32'h3FF);
    chk_rd(0, 2'd3, "post_rst_ecap0", 32'h3FF);
    chk_rd(1, 2'd3, "post_rst_ecap1", 32'h0);
    chk_rd(2, 2'd3, "post_rst_ecap2", 32'h3FF);
    chk_irq(0, "post_rst_irq0", 1'b0);
    chk_irq(2, "post_rst_irq2", 1'b1);

    // Partial write-1-to-clear.
    wr(2'd3, 32'h0F0);
    chk_rd(0, 2'd3, "pclr_ecap0", 32'h30F);
    chk_rd(2, 2'd3, "pclr_ecap2", 32'h30F);

    wr(2'd3, 32'h3FF);
    wr(2'd2, 32'h0);
    tick(2);
    chk_irq(2, "unmask_irq2", 1'b0);
    chk_rd(2, 2'd2, "mask_wr2", 32'h0);

    // Writes to DATA and RSVD have no effect.
    wr(2'd0, 32'h0);
    chk_rd(0, 2'd0, "data_ro", 32'h3FF);
    wr(2'd1, 32'hFFFF_FFFF);
    chk_rd(0, 2'd1, "rsvd_zero", 32'h0);

    // Falling edges on all bits.
    in_port = 10'h000;
    tick();
    chk_rd(1, 2'd0, "fall_data_early", 32'h3FF);
    tick(3);
    chk_rd(1, 2'd3, "fall_ecap1", 32'h3FF);
    chk_rd(2, 2'd3, "fall_ecap2", 32'h3FF);
    chk_rd(0, 2'd3, "fall_ecap0", 32'h0);
    wr(2'd3, 32'h3FF);

    // Data path latency.
    in_port = 10'h2A5;
    tick();
    chk_rd(0, 2'd0, "data_cyc1", 32'h0);
    tick();
    chk_rd(0, 2'd0, "data_cyc2", 32'h2A5);
    tick(2);
    chk_rd(0, 2'd3, "rise_ecap0", 32'h2A5);
    chk_rd(1, 2'd3, "rise_ecap1", 32'h0);
    chk_rd(2, 2'd3, "rise_ecap2", 32'h2A5);
    wr(2'd3, 32'h3FF);
    in_port = 10'h000;
    tick(4);
    chk_rd(1, 2'd3, "fall2_ecap1", 32'h2A5);
    chk_rd(0, 2'd3, "fall2_ecap0", 32'h0);
    wr(2'd3, 32'h3FF);

    // Rising pulse on bit 0 with irq enabled.
    wr(2'd2, 32'h001);
    in_port = 10'h001;
    tick(2);
    chk_rd(0, 2'd3, "pulse_ecap_early", 32'h0);
    tick();
    chk_rd(0, 2'd3, "pulse_ecap_set", 32'h001);
    chk_irq(0, "pulse_irq_early", 1'b0);
    in_port = 10'h000;
    tick();
    chk_rd(0, 2'd3, "pulse_ecap_c3", 32'h001);
    chk_irq(0, "pulse_irq_c3", 1'b1);
    wr(2'd3, 32'h001);
    chk_rd(0, 2'd3, "w1c_ecap0", 32'h0);
    chk_irq(0, "w1c_irq_hold", 1'b1);
    tick();
    chk_irq(0, "w1c_irq_drop", 1'b0);
    chk_rd(1, 2'd3, "pulse_fall_ecap1", 32'h001);
    tick();
    chk_irq(1, "pulse_fall_irq1", 1'b1);
    wr(2'd3, 32'h3FF);
    wr(2'd2, 32'h0);
    tick(2);

    // Mask gating on bit 5.
    in_port = 10'h020;
    tick(4);
    chk_rd(0, 2'd3, "gate_ecap0", 32'h020);
    chk_irq(0, "gate_irq_masked", 1'b0);
    wr(2'd2, 32'h020);
    chk_irq(0, "gate_irq_w1", 1'b0);
    tick();
    chk_irq(0, "gate_irq_w2", 1'b1);
    wr(2'd3, 32'h3FF);

    // Clear and new edge on bit 2 in the same cycle: set wins.
    in_port = 10'h024;
    tick(2);
    wr(2'd3, 32'h004);
    chk_rd(0, 2'd3, "collide_ecap0", 32'h004);
    tick();
    chk_irq(0, "collide_irq0", 1'b0);
    wr(2'd3, 32'h004);
    chk_rd(0, 2'd3, "after_collide_clr", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/neos2test_pio_in.md
# neos2test_pio_in

Avalon-MM slave input PIO with edge capture and interrupt generation. It is the inbound counterpart of the system's 10-bit output PIO. It samples a 10-bit asynchronous `in_port` (switches, buttons, status lines), synchronizes it, and latches selected edges into a capture register. It raises a level interrupt to the Nios II processor through a mask register. It sits on the same Avalon interconnect as the other PIOs, with zero wait states and zero read latency.

## Interface
Parameters:
- `WIDTH`, 10: number of input bits (1..32).
- `EDGE_TYPE`, 0: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.
- `RESET_MASK`, 0: reset value of the interrupt-mask register.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `address`, in, 2: register word offset.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe. Qualified by `chipselect`.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: read data. Combinational from `address`; read latency 0.
- `in_port`, in, WIDTH: asynchronous external inputs.
- `irq`, out, 1: level interrupt, registered.

## Operation
Register map (word offsets):
- 0 DATA, read-only: synchronized `in_port` (`sync2`). Writes are ignored.
- 1 RSVD: reads 0; writes are ignored.
- 2 IRQMASK, read/write: bits [WIDTH-1:0]. Bit set = capture bit may drive `irq`.
- 3 EDGECAP, read / write-1-to-clear. A written 1 clears that bit; a written 0 leaves it unchanged.

Datapath:
- Two-flop synchronizer `in_port` → `sync1` → `sync2`, then a history flop `prev` <= `sync2`.
- Edge vector:
  - rising = `sync2 & ~prev`
  - falling = `~sync2 & prev`
  - any = `sync2 ^ prev`
- Capture update each cycle: `edgecap <= (edgecap & ~clr) | edge`.
  - `clr` = `writedata[WIDTH-1:0]` when `chipselect && !write_n && address==3`, else 0.
  - On a simultaneous clear and new edge of the same bit, **set wins**.
- `irq <= |(edgecap & irqmask)`. Evaluated on the registered `edgecap` and `irqmask` values.
- `readdata` = selected register, zero-extended to 32 bits. Bits [31:WIDTH] always read 0.
- Reads have no side effects. `read_n` is not part of the interface.

Reset values (`reset_n` low, asynchronous):
- `sync1`, `sync2`, `prev`, `edgecap`, `irq` = 0.
- `irqmask` = `RESET_MASK`.
- `readdata` follows the address mux over the reset registers. At offset 2 it reads `RESET_MASK`; elsewhere 0.

Reset edge case: with `in_port` held high through reset deassertion, a rising edge is captured 2 cycles later. This is intended; software clears EDGECAP at init.

## Timing
- Cycle 0 = first rising `clk` edge at which `in_port` meets setup.
- `sync2` (DATA) updates at cycle 1.
- `prev` updates at cycle 2; the edge term is valid during the cycle between those two edges.
- EDGECAP bit sets at cycle 2.
- `irq` asserts at cycle 3 if the bit is masked in.
- Writes take effect at the clock edge where `chipselect && !write_n` is sampled. The new mask or cleared capture is visible to `readdata` in the next cycle, and to `irq` one cycle later.
- A pulse shorter than one clock period may be missed. A pulse of 2 or more cycles is guaranteed to be captured.
- `irq` deasserts one cycle after the last unmasked capture bit is cleared or masked off.

## Structure
- Package `neos2test_pio_pkg`:
  - Offsets: `PIO_DATA=0`, `PIO_RSVD=1`, `PIO_IRQMASK=2`, `PIO_EDGECAP=3`.
  - Edge-type constants: `EDGE_RISE=0`, `EDGE_FALL=1`, `EDGE_ANY=2`.
- Sub-module `neos2test_sync2`: parameterized-width two-flop synchronizer with async active-low reset to 0. Instantiated once.
- Everything else is in the top module.

## Test plan
- **Reset:** assert `reset_n`=0 with `in_port`=10'h3FF.
  - Required: `irq`=0. Reads at offsets 0/1/3 = 0; offset 2 = `RESET_MASK`.
- **Data path:** drive `in_port`=10'h2A5.
  - Required: DATA reads 0x000002A5 from 2 cycles after the change; never earlier than cycle 1.
- **Rising capture + IRQ** (`EDGE_TYPE`=0): write IRQMASK=0x001, then pulse `in_port[0]` 0→1→0 for 3 cycles.
  - Required: EDGECAP=0x001 and `irq`=1 at cycle 3.
  - Then write EDGECAP=0x001. Required: EDGECAP=0 and `irq`=0 one cycle later.
- **Mask gating:** with IRQMASK=0, create a rising edge on bit 5.
  - Required: EDGECAP=0x020, `irq` stays 0.
  - Then write IRQMASK=0x020. Required: `irq`=1 two cycles after the write.
- **Clear/set collision:** write EDGECAP=0x004 in the same cycle that bit 2's edge term is active.
  - Required: bit 2 remains 1.
- **Partial clear / edge modes:**
  - With EDGECAP=0x3FF, write 0x0F0. Required: EDGECAP=0x30F.
  - Repeat with `EDGE_TYPE`=1 and 2: falling-only and both edges set bits as defined above.
